// File: rtl/bus_arbiter.sv
// Round-robin arbiter for a shared PCI-style bus. Grants one master at a time,
// tracks the frame and data phase, and uses a watchdog to recover a hung bus.
module bus_arbiter #(
   parameter int NUM_MASTERS = 4,
   parameter int TIMEOUT     = 16
) (
   input  logic                   CLK,
   input  logic                   RST_B,
   input  logic [NUM_MASTERS-1:0] REQ_B,
   output logic [NUM_MASTERS-1:0] GNT_B,
   input  logic                   FRAME_B,
   input  logic                   IRDY_B,
   input  logic                   TRDY_B,
   output logic [2:0]             owner,
   output logic                   bus_busy,
   output logic                   timeout_err
);

   typedef enum logic [1:0] {IDLE, GRANT, BUSY, RECOVER} state_t;

   state_t                 state, state_nx;
   logic [NUM_MASTERS-1:0] gnt_nx;
   logic [2:0]             owner_nx, win;
   logic [7:0]             wdog, wdog_nx;
   logic                   terr_nx, any_req, frame_a, done_a, expire;

   // An x or z on a shared line makes the comparison unknown, so the if below
   // falls through and the line is treated as deasserted.
   assign frame_a = (FRAME_B == 1'b0);
   assign done_a  = (IRDY_B == 1'b0) && (TRDY_B == 1'b0);
   assign expire  = (wdog == 8'(TIMEOUT - 1));

   // Scan from lowest priority to highest so the last hit is the winner;
   // owner itself sits at offset NUM_MASTERS, i.e. lowest priority.
   always_comb begin
      win     = owner;
      any_req = 1'b0;
      for (int i = NUM_MASTERS; i >= 1; i--) begin
         for (int m = 0; m < NUM_MASTERS; m++) begin
            if (m == (int'(owner) + i) % NUM_MASTERS && !REQ_B[m]) begin
               win     = 3'(m);
               any_req = 1'b1;
            end
         end
      end
   end

   always_comb begin
      state_nx = state;
      gnt_nx   = GNT_B;
      owner_nx = owner;
      wdog_nx  = wdog;
      terr_nx  = 1'b0;
      case (state)
         IDLE: begin
            gnt_nx = '1;
            if (any_req) begin
               state_nx = GRANT;
               owner_nx = win;
               wdog_nx  = '0;
               for (int m = 0; m < NUM_MASTERS; m++)
                  gnt_nx[m] = (3'(m) != win);
            end
         end
         GRANT: begin
            // Frame start beats a coincident watchdog expiry.
            if (frame_a) begin
               state_nx = BUSY;
               gnt_nx   = '1;
               wdog_nx  = '0;
            end else if (expire) begin
               state_nx = RECOVER;
               gnt_nx   = '1;
               terr_nx  = 1'b1;
            end else begin
               wdog_nx = wdog + 8'd1;
            end
         end
         BUSY: begin
            gnt_nx = '1;
            if (done_a) begin
               state_nx = RECOVER;
            end else if (expire) begin
               state_nx = RECOVER;
               terr_nx  = 1'b1;
            end else begin
               wdog_nx = wdog + 8'd1;
            end
         end
         RECOVER: begin
            gnt_nx   = '1;
            state_nx = IDLE;
         end
         default: begin
            gnt_nx   = '1;
            state_nx = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST_B) begin
      if (!RST_B) begin
         state       <= IDLE;
         GNT_B       <= '1;
         owner       <= 3'(NUM_MASTERS - 1);
         wdog        <= '0;
         timeout_err <= 1'b0;
      end else begin
         state       <= state_nx;
         GNT_B       <= gnt_nx;
         owner       <= owner_nx;
         wdog        <= wdog_nx;
         timeout_err <= terr_nx;
      end
   end

   assign bus_busy = (state != IDLE);

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: phase-level reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_bus_arbiter;
   localparam int NM = 4;
   localparam int TO = 16;

   logic          CLK = 1'b0;
   logic          RST_B;
   logic [NM-1:0] REQ_B;
   logic [NM-1:0] GNT_B;
   logic          FRAME_B, IRDY_B, TRDY_B;
   logic [2:0]    owner;
   logic          bus_busy, timeout_err;

   int checks = 0;
   int errors = 0;

   bus_arbiter #(.NUM_MASTERS(NM), .TIMEOUT(TO)) dut (
      .CLK(CLK), .RST_B(RST_B), .REQ_B(REQ_B), .GNT_B(GNT_B),
      .FRAME_B(FRAME_B), .IRDY_B(IRDY_B), .TRDY_B(TRDY_B),
      .owner(owner), .bus_busy(bus_busy), .timeout_err(timeout_err)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: phase 0 idle, 1 granted, 2 data transfer, 3 turnaround.
   // m_age is the number of whole cycles already spent in the current phase.
   int         m_ph = 0, m_own = NM - 1, m_age = 0;
   logic       m_terr = 1'b0;
   int         k, nxt;
   logic       found;
   logic [3:0] r;

   always @(posedge CLK or negedge RST_B) begin
      if (!RST_B) begin
         m_ph = 0; m_own = NM - 1; m_age = 0; m_terr = 1'b0;
      end else begin
         m_terr = 1'b0;
         case (m_ph)
            0: begin
               found = 1'b0;
               nxt   = m_own;
               for (int i = 1; i <= NM; i++) begin
                  k = (m_own + i) % NM;
                  r = REQ_B >> k;
                  if (!found && r[0] === 1'b0) begin found = 1'b1; nxt = k; end
               end
               if (found) begin m_own = nxt; m_ph = 1; m_age = 0; end
            end
            1: begin
               if (FRAME_B === 1'b0) begin m_ph = 2; m_age = 0; end
               else if (m_age + 1 == TO) begin m_ph = 3; m_terr = 1'b1; end
               else m_age++;
            end
            2: begin
               if (IRDY_B === 1'b0 && TRDY_B === 1'b0) m_ph = 3;
               else if (m_age + 1 == TO) begin m_ph = 3; m_terr = 1'b1; end
               else m_age++;
            end
            default: m_ph = 0;
         endcase
      end
   end

   logic [NM-1:0] e_gnt;
   always @(negedge CLK) begin
      e_gnt = '1;
      for (int m = 0; m < NM; m++)
         if (m_ph == 1 && m == m_own) e_gnt[m] = 1'b0;
      chk("gnt_b", 32'(GNT_B), 32'(e_gnt));
      chk("owner", 32'(owner), m_own);
      chk("bus_busy", 32'(bus_busy), 32'(m_ph != 0));
      chk("timeout_err", 32'(timeout_err), 32'(m_terr));
      chk("one_grant", 32'($countones(~GNT_B) <= 1), 1);
   end

   // Log every new grant for order checks.
   int   gq[$];
   logic prev_none = 1'b1;
   always @(negedge CLK) begin
      if (prev_none && GNT_B != '1)
         for (int m = 0; m < NM; m++) if (GNT_B[m] == 1'b0) gq.push_back(m);
      prev_none = (GNT_B == '1);
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // From GRANT: frame, one data phase, turnaround, back to IDLE.
   task automatic run_xact();
      FRAME_B = 1'b0; tick();
      FRAME_B = 1'b1; IRDY_B = 1'b0; TRDY_B = 1'b0; tick();
      IRDY_B = 1'b1; TRDY_B = 1'b1; tick();
   endtask

   int n;
   int exp_order[5] = '{0, 1, 2, 3, 0};

   initial begin
      #100000;
      $display("FAIL global_timeout");
      $fatal(1);
   end

   initial begin
      RST_B = 1'b0; REQ_B = '1; FRAME_B = 1'b1; IRDY_B = 1'b1; TRDY_B = 1'b1;
      tick(); tick();
      chk("rst_gnt", 32'(GNT_B), 32'hF);
      chk("rst_owner", 32'(owner), 3);
      chk("rst_busy", 32'(bus_busy), 0);

      // Master 0 wins first after reset.
      RST_B = 1'b1; REQ_B = 4'b0000;
      tick();
      chk("first_gnt", 32'(GNT_B), 32'hE);
      chk("first_owner", 32'(owner), 0);
      REQ_B = '1;
      run_xact();

      // Single transaction by master 2 with one wait cycle in the data phase.
      REQ_B = 4'b1011; tick();
      chk("m2_gnt", 32'(GNT_B), 32'hB);
      chk("m2_owner", 32'(owner), 2);
      FRAME_B = 1'b0; REQ_B = '1; tick();
      chk("m2_busy_gnt", 32'(GNT_B), 32'hF);
      chk("m2_busy", 32'(bus_busy), 1);
      FRAME_B = 1'b1; tick();
      IRDY_B = 1'b0; TRDY_B = 1'b0; tick();
      chk("m2_rec_busy", 32'(bus_busy), 1);
      chk("m2_rec_terr", 32'(timeout_err), 0);
      IRDY_B = 1'b1; TRDY_B = 1'b1; tick();
      chk("m2_idle", 32'(bus_busy), 0);

      // All masters requesting: rotation starting from master 0.
      RST_B = 1'b0; tick(); RST_B = 1'b1;
      gq.delete();
      REQ_B = 4'b0000;
      for (int t = 0; t < 5; t++) begin tick(); run_xact(); end
      REQ_B = '1;
      chk("rr_count", gq.size(), 5);
      for (int t = 0; t < 5 && t < gq.size(); t++) chk("rr_order", gq[t], exp_order[t]);

      // Master 1 never starts a frame and drops its request: watchdog recovery.
      REQ_B = 4'b1101; tick();
      chk("to_owner", 32'(owner), 1);
      REQ_B = 4'b0111;
      n = 0;
      while (GNT_B == 4'b1101 && n < 40) begin n++; tick(); end
      chk("to_grant_cycles", n, 16);
      chk("to_terr", 32'(timeout_err), 1);
      chk("to_rec_busy", 32'(bus_busy), 1);
      tick();
      chk("to_terr_pulse", 32'(timeout_err), 0);
      tick();
      chk("to_next_gnt", 32'(GNT_B), 32'h7);
      chk("to_next_owner", 32'(owner), 3);
      REQ_B = '1;
      run_xact();

      // Frame on the same edge the watchdog would expire in GRANT.
      REQ_B = 4'b1110; tick(); REQ_B = '1;
      repeat (15) tick();
      FRAME_B = 1'b0; tick();
      chk("fw_busy", 32'(bus_busy), 1);
      chk("fw_terr", 32'(timeout_err), 0);
      FRAME_B = 1'b1; IRDY_B = 1'b0; TRDY_B = 1'b0; tick();
      chk("fw_rec_terr", 32'(timeout_err), 0);
      IRDY_B = 1'b1; TRDY_B = 1'b1; tick();

      // Completion on the same edge the watchdog would expire in BUSY.
      REQ_B = 4'b1101; tick(); REQ_B = '1;
      FRAME_B = 1'b0; tick(); FRAME_B = 1'b1;
      repeat (15) tick();
      IRDY_B = 1'b0; TRDY_B = 1'b0; tick();
      chk("cw_terr", 32'(timeout_err), 0);
      chk("cw_busy", 32'(bus_busy), 1);
      IRDY_B = 1'b1; TRDY_B = 1'b1; tick();

      // Data phase never completes: watchdog recovery out of BUSY.
      REQ_B = 4'b1011; tick(); REQ_B = '1;
      FRAME_B = 1'b0; tick(); FRAME_B = 1'b1;
      repeat (15) tick();
      chk("bt_pre_terr", 32'(timeout_err), 0);
      tick();
      chk("bt_terr", 32'(timeout_err), 1);
      tick();
      chk("bt_idle", 32'(bus_busy), 0);

      // Asynchronous reset in the middle of a BUSY cycle.
      REQ_B = 4'b1101; tick(); REQ_B = '1;
      FRAME_B = 1'b0; tick(); FRAME_B = 1'b1;
      #2 RST_B = 1'b0;
      #1;
      chk("ar_gnt", 32'(GNT_B), 32'hF);
      chk("ar_busy", 32'(bus_busy), 0);
      chk("ar_owner", 32'(owner), 3);
      tick();
      RST_B = 1'b1; REQ_B = 4'b1011;
      chk("ar_no_early_gnt", 32'(GNT_B), 32'hF);
      tick();
      chk("ar_gnt_after", 32'(GNT_B), 32'hB);
      chk("ar_owner_after", 32'(owner), 2);
      REQ_B = '1;
      run_xact();
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
